change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL provide the following parameter: DENOM_HI, default 5, value in money units of the largest coin (legal range 3..15).
REQ-002 The block SHALL provide the following ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 The block SHALL provide the following ports: rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL provide the following ports: start  in  1  one-cycle request to dispense a completed vendingmachine transaction.
REQ-005 The block SHALL provide the following ports: posibility  in  1  vendingmachine accept flag (1 = sale accepted).
REQ-006 The block SHALL provide the following ports: code  in  2  product code of the sale.
REQ-007 The block SHALL provide the following ports: count  in  3  number of items sold.
REQ-008 The block SHALL provide the following ports: money  in  4  amount inserted by the customer.
REQ-009 The block SHALL provide the following ports: remaining  in  4  change owed on an accepted sale.
REQ-010 The block SHALL provide the following ports: item_valid  out  1  one item is offered to the item chute.
REQ-011 The block SHALL provide the following ports: item_code  out  2  code of the offered item.
REQ-012 The block SHALL provide the following ports: item_ack  in  1  chute has taken the item.
REQ-013 The block SHALL provide the following ports: coin_valid  out  1  one coin is offered to the coin hopper.
REQ-014 The block SHALL provide the following ports: coin_val  out  2  offered coin: 2'b10 = DENOM_HI, 2'b01 = 2, 2'b00 = 1.
REQ-015 The block SHALL provide the following ports: coin_ack  in  1  hopper has released the coin.
REQ-016 The block SHALL provide the following ports: busy  out  1  high whenever the FSM is not in IDLE.
REQ-017 The block SHALL provide the following ports: done  out  1  one-cycle completion pulse.
REQ-018 The block SHALL provide the following ports: fault  out  1  sticky handshake-timeout flag.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, VEND, CHANGE and DONE.
REQ-020 In IDLE, start=1 SHALL latch code, count, money, remaining and posibility, and SHALL load the refund amount: remaining if posibility=1, otherwise money.
REQ-021 From IDLE on start, the next state SHALL be VEND if posibility=1 and count!=0, otherwise CHANGE.
REQ-022 In VEND, item_valid SHALL be 1 and item_code SHALL equal the latched code.
REQ-023 In VEND, each cycle with item_ack=1 SHALL decrement the item counter; after the last item the state SHALL move to CHANGE, with no bubble cycle between items.
REQ-024 In CHANGE with amount=0, the state SHALL move to DONE.
REQ-025 In CHANGE with amount!=0, coin_valid SHALL be 1 and coin_val SHALL be the greedy choice: DENOM_HI if amount>=DENOM_HI, else 2 if amount>=2, else 1.
REQ-026 In CHANGE, coin_ack=1 SHALL subtract the offered coin value from amount; amount is 4-bit and SHALL never underflow.
REQ-027 item_valid and coin_valid SHALL never be high together.
REQ-028 item_valid and coin_valid SHALL hold their values stable until acked.
REQ-029 An ack arriving while the matching valid is low SHALL be ignored.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 start SHALL be ignored while busy=1, and input changes while busy SHALL have no effect.
REQ-032 Zero-change and zero-count transactions SHALL still pass through DONE, giving at least two cycles from start to done.

Reset
REQ-033 rst=1 SHALL force IDLE and clear item_valid, coin_valid, busy, done, fault and all latched registers on the next edge, including mid-handshake.
REQ-034 rst SHALL take priority over start and over acks on the same edge.
REQ-035 After reset, no pending item or coin SHALL be re-offered.

Configuration
REQ-036 The macro DISPENSE_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-037 With DISPENSE_TIMEOUT_EN defined, a 4-bit counter SHALL count consecutive cycles of an unacked valid.
REQ-038 With DISPENSE_TIMEOUT_EN defined, reaching 15 SHALL set fault=1 and drop the valid.
REQ-039 With DISPENSE_TIMEOUT_EN defined, after a timeout the FSM SHALL go to DONE (done pulse) then IDLE.
REQ-040 With DISPENSE_TIMEOUT_EN defined, fault SHALL stay set until rst, while new transactions remain allowed.
REQ-041 Without DISPENSE_TIMEOUT_EN, fault SHALL be tied to 0, no counter SHALL exist, and the FSM SHALL wait for ack indefinitely.

Verification
REQ-042 The bench SHALL cover: posibility=1, code=2'b00, count=1, remaining=4'd9, acks immediate -> one item with item_code=00, then coins 5,2,2 (10,01,01), then done; 6 cycles from start to done.
REQ-043 The bench SHALL cover: posibility=0, money=4'd15, count=3 -> no item_valid, coins 5,5,5, done.
REQ-044 The bench SHALL cover: posibility=1, count=3, remaining=0, item_ack delayed 2 cycles each -> item_valid held stable, 3 items, no coin, done.
REQ-045 The bench SHALL cover: start pulsed again while busy with different inputs -> ignored; the original sequence completes unchanged.
REQ-046 The bench SHALL cover: rst asserted while coin_valid=1 -> next cycle all outputs 0 and IDLE; a following start runs normally.
REQ-047 The bench SHALL cover, with DISPENSE_TIMEOUT_EN defined: coin_ack never asserted -> after 15 cycles fault=1, coin_valid=0, done pulse; fault persists until rst.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/handshake bundle between a vending controller and the change dispenser
// master: controller/chute/hopper side (drives start, sale data and acks)
// slave : dispenser side (drives item/coin offers, busy, done, fault)
interface change_dispenser_if;
  logic       start, posibility;
  logic [1:0] code;
  logic [2:0] count;
  logic [3:0] money, remaining;
  logic       item_valid, item_ack, coin_valid, coin_ack, busy, done, fault;
  logic [1:0] item_code, coin_val;
  modport master (
    output start, posibility, code, count, money, remaining, item_ack, coin_ack,
    input  item_valid, item_code, coin_valid, coin_val, busy, done, fault
  );
  modport slave (
    input  start, posibility, code, count, money, remaining, item_ack, coin_ack,
    output item_valid, item_code, coin_valid, coin_val, busy, done, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: hands out sold items, then greedy change coins, one valid/ack handshake at a time
// ports: clk, rst (sync active-high); bus (slave): start/posibility/code/count/money/remaining in,
//        item_valid/item_code/item_ack, coin_valid/coin_val/coin_ack, busy, done, fault
// DISPENSE_TIMEOUT_EN: when defined, an offer unacked for 15 cycles sets sticky fault and ends the transaction
module change_dispenser #(
  parameter int DENOM_HI = 5
) (
  input logic             clk,
  input logic             rst,
  change_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE, DONE} state_t;
  localparam logic [3:0] HI = 4'(DENOM_HI);
  state_t     state_q;
  logic [2:0] cnt_q;
  logic [3:0] amt_q, amt_d, refund_d;
  logic       item_valid_q, coin_valid_q, expire;
  logic [1:0] item_code_q, coin_val_q, coin_val_d;
  function automatic logic [1:0] pick(input logic [3:0] a);
    return a >= HI ? 2'b10 : a >= 4'd2 ? 2'b01 : 2'b00;
  endfunction
  // greedy choice never exceeds amt_q, so the subtraction cannot underflow
  always_comb begin
    refund_d   = bus.posibility ? bus.remaining : bus.money;
    amt_d      = amt_q - (coin_val_q == 2'b10 ? HI : coin_val_q == 2'b01 ? 4'd2 : 4'd1);
    coin_val_d = pick(amt_d);
  end
`ifdef DISPENSE_TIMEOUT_EN
  logic [3:0] tmo_q;
  logic       fault_q, stall;
  assign stall  = (item_valid_q & ~bus.item_ack) | (coin_valid_q & ~bus.coin_ack);
  // the 15th consecutive unacked cycle is the one that expires
  assign expire = stall && tmo_q == 4'd14;
  assign bus.fault = fault_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= stall && !expire ? tmo_q + 4'd1 : 4'd0;
      fault_q <= fault_q | expire;
    end
  end
`else
  assign expire    = 1'b0;
  assign bus.fault = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      amt_q        <= '0;
      item_valid_q <= 1'b0;
      coin_valid_q <= 1'b0;
      item_code_q  <= '0;
      coin_val_q   <= '0;
    end else if (expire) begin
      state_q      <= DONE;
      item_valid_q <= 1'b0;
      coin_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          item_code_q <= bus.code;
          cnt_q       <= bus.count;
          amt_q       <= refund_d;
          if (bus.posibility && bus.count != 3'd0) begin
            state_q      <= VEND;
            item_valid_q <= 1'b1;
          end else begin
            state_q      <= CHANGE;
            coin_valid_q <= refund_d != 4'd0;
            coin_val_q   <= pick(refund_d);
          end
        end
        VEND: if (bus.item_ack) begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q      <= CHANGE;
            item_valid_q <= 1'b0;
            coin_valid_q <= amt_q != 4'd0;
            coin_val_q   <= pick(amt_q);
          end
        end
        CHANGE: if (!coin_valid_q) state_q <= DONE;
        else if (bus.coin_ack) begin
          amt_q        <= amt_d;
          coin_valid_q <= amt_d != 4'd0;
          coin_val_q   <= coin_val_d;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.item_valid = item_valid_q;
  assign bus.item_code  = item_code_q;
  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_val   = coin_val_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, corner sequences and random transactions against a sale/change model
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  change_dispenser_if bus();
  change_dispenser dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  typedef struct {
    logic p; logic [1:0] c; logic [2:0] n; logic [3:0] m, r;
    int dly; int exp_items; int exp_coins; int exp_cyc;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // what the sale should produce: items handed out and the greedy coin list (largest coin 5)
  function automatic void model(input logic p, input logic [2:0] n, input logic [3:0] m, r,
                                output int ni, output int coins[$]);
    int a;
    a = p ? int'(r) : int'(m);
    ni = p ? int'(n) : 0;
    coins = {};
    while (a > 0) begin
      int v;
      v = a >= 5 ? 5 : a >= 2 ? 2 : 1;
      coins.push_back(v);
      a -= v;
    end
  endfunction
  function automatic int coin_units(input logic [1:0] v);
    return v == 2'b10 ? 5 : v == 2'b01 ? 2 : v == 2'b00 ? 1 : -1;
  endfunction
  task automatic idle_inputs();
    bus.start = 0; bus.posibility = 0; bus.code = 0; bus.count = 0;
    bus.money = 0; bus.remaining = 0; bus.item_ack = 0; bus.coin_ack = 0;
  endtask
  // dly<0 picks a random ack delay per handshake; junk scrambles inputs/start and spurious acks while busy
  task automatic run(input logic p, input logic [1:0] c, input logic [2:0] n, input logic [3:0] m, r,
                     input int dly, input bit junk, output int cyc, output int gi, output int gc);
    int ni, w, need;
    int exp_coins[$], got_items[$], got_coins[$];
    logic piv, pcv, pack;
    logic [1:0] pcode, pval;
    w = 0; piv = 0; pcv = 0; pack = 0; pcode = 0; pval = 0;
    model(p, n, m, r, ni, exp_coins);
    need = dly < 0 ? int'($urandom_range(0, 3)) : dly;
    bus.posibility = p; bus.code = c; bus.count = n; bus.money = m; bus.remaining = r; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    cyc = 0;
    while (1) begin
      cyc++;
      if (bus.done) break;
      if (cyc > 300) begin
        chk("done_timeout", 0, 1);
        break;
      end
      chk("exclusive", {31'd0, bus.item_valid & bus.coin_valid}, 0);
      if (piv && !pack) chk("item_hold", {bus.item_valid, bus.item_code}, {1'b1, pcode});
      if (pcv && !pack) chk("coin_hold", {bus.coin_valid, bus.coin_val}, {1'b1, pval});
      pack = (bus.item_valid || bus.coin_valid) && w >= need;
      if (pack) begin
        w = 0;
        need = dly < 0 ? int'($urandom_range(0, 3)) : dly;
        if (bus.item_valid) got_items.push_back(int'(bus.item_code));
        else got_coins.push_back(coin_units(bus.coin_val));
      end else if (bus.item_valid || bus.coin_valid) w++;
      bus.item_ack = bus.item_valid ? pack : (junk ? 1'($urandom) : 1'b0);
      bus.coin_ack = bus.coin_valid ? pack : (junk ? 1'($urandom) : 1'b0);
      piv = bus.item_valid; pcv = bus.coin_valid; pcode = bus.item_code; pval = bus.coin_val;
      if (junk) begin
        bus.start = 1'($urandom); bus.posibility = 1'($urandom); bus.code = 2'($urandom);
        bus.count = 3'($urandom); bus.money = 4'($urandom); bus.remaining = 4'($urandom);
      end
      @(negedge clk);
    end
    bus.item_ack = 0; bus.coin_ack = 0; bus.start = 0;
    gi = got_items.size();
    gc = got_coins.size();
    chk("item_total", gi, ni);
    foreach (got_items[i]) chk("item_code", got_items[i], int'(c));
    chk("coin_total", gc, exp_coins.size());
    foreach (got_coins[i]) if (i < exp_coins.size()) chk("coin_value", got_coins[i], exp_coins[i]);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 0);
    chk("idle_after_done", {31'd0, bus.busy}, 0);
  endtask
  int cyc, gi, gc, n;
  initial begin
    vecs[0] = '{1, 2'b00, 3'd1, 4'd0, 4'd9, 0, 1, 3, 6};
    vecs[1] = '{0, 2'b10, 3'd3, 4'd15, 4'd2, 0, 0, 3, 5};
    vecs[2] = '{1, 2'b11, 3'd3, 4'd6, 4'd0, 2, 3, 0, 11};
    vecs[3] = '{1, 2'b01, 3'd0, 4'd7, 4'd4, 0, 0, 2, 4};
    vecs[4] = '{0, 2'b01, 3'd2, 4'd0, 4'd8, 0, 0, 0, 2};
    vecs[5] = '{1, 2'b01, 3'd7, 4'd15, 4'd14, 1, 7, 4, 24};
    vecs[6] = '{1, 2'b10, 3'd2, 4'd3, 4'd1, 0, 2, 1, 5};
    vecs[7] = '{1, 2'b00, 3'd1, 4'd9, 4'd5, 0, 1, 1, 4};
    vecs[8] = '{1, 2'b11, 3'd1, 4'd9, 4'd3, 3, 1, 2, 14};
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_item_valid", {31'd0, bus.item_valid}, 0);
    chk("rst_coin_valid", {31'd0, bus.coin_valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_fault", {31'd0, bus.fault}, 0);
    rst = 0;
    @(negedge clk);
    foreach (vecs[i]) begin
      run(vecs[i].p, vecs[i].c, vecs[i].n, vecs[i].m, vecs[i].r, vecs[i].dly, 0, cyc, gi, gc);
      chk("vec_cycles", cyc, vecs[i].exp_cyc);
      chk("vec_items", gi, vecs[i].exp_items);
      chk("vec_coins", gc, vecs[i].exp_coins);
    end
    // restart attempts and input churn while busy must not disturb the first sale
    run(1, 2'b00, 3'd1, 4'd0, 4'd9, 0, 1, cyc, gi, gc);
    chk("busy_start_cycles", cyc, 6);
    // reset while a coin is offered, with start and ack on the same edge
    bus.posibility = 0; bus.money = 4'd9; bus.count = 3'd2; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    chk("pre_rst_coin", {bus.coin_valid, bus.coin_val}, {1'b1, 2'b10});
    rst = 1; bus.coin_ack = 1; bus.start = 1;
    @(negedge clk);
    rst = 0; bus.coin_ack = 0; bus.start = 0;
    chk("mid_rst_outputs", {bus.item_valid, bus.coin_valid, bus.busy, bus.done, bus.fault}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_reoffer", {bus.coin_valid, bus.busy}, 0);
    end
    run(0, 2'b00, 3'd0, 4'd4, 4'd0, 0, 0, cyc, gi, gc);
    chk("post_rst_cycles", cyc, 4);
`ifdef DISPENSE_TIMEOUT_EN
    bus.posibility = 0; bus.money = 4'd5; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    n = 0;
    while (bus.coin_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_fault", {31'd0, bus.fault}, 1);
    chk("tmo_coin_drop", {31'd0, bus.coin_valid}, 0);
    chk("tmo_done", {31'd0, bus.done}, 1);
    @(negedge clk);
    chk("tmo_idle", {bus.done, bus.busy, bus.fault}, 3'b001);
    run(1, 2'b10, 3'd1, 4'd0, 4'd2, 0, 0, cyc, gi, gc);
    chk("tmo_next_cycles", cyc, 4);
    chk("fault_sticky", {31'd0, bus.fault}, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("fault_cleared", {31'd0, bus.fault}, 0);
`else
    bus.posibility = 0; bus.money = 4'd2; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (40) begin
      chk("wait_forever", {bus.coin_valid, bus.coin_val, bus.fault}, 4'b1010);
      @(negedge clk);
    end
    bus.coin_ack = 1;
    @(negedge clk);
    bus.coin_ack = 0;
    chk("late_ack_empty", {bus.coin_valid, bus.done}, 0);
    @(negedge clk);
    chk("late_ack_done", {31'd0, bus.done}, 1);
    @(negedge clk);
`endif
    for (int k = 0; k < 40; k++) begin
      run(1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), -1, 1, cyc, gi, gc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
